// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size encodings and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_unit_if.sv
// Bundle of the core-side request/response and data-memory bus signals of the LSU.
interface lsu_mem_unit_if;

    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_error;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport slave (
        input  req_valid, mem_read, mem_write, funct3, addr, wdata,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output busy, done, rdata, misaligned, bus_error,
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata
    );

    modport master (
        output req_valid, mem_read, mem_write, funct3, addr, wdata,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  busy, done, rdata, misaligned, bus_error,
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: legality check, byte enables, store replication and
// load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic        o_legal,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);

    logic        w_dir_ok;
    logic [31:0] w_shifted;

    assign w_dir_ok  = i_mem_read ^ i_mem_write;
    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_legal = 1'b0;
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_load  = w_shifted;
        case (i_funct3)
            F3_B: begin
                o_legal = w_dir_ok;
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_load  = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_BU: begin
                o_legal = w_dir_ok && i_mem_read;
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_load  = {24'd0, w_shifted[7:0]};
            end
            F3_H: begin
                o_legal = w_dir_ok && !i_offset[0];
                o_be    = 4'b0011 << {i_offset[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_load  = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_HU: begin
                o_legal = w_dir_ok && i_mem_read && !i_offset[0];
                o_be    = 4'b0011 << {i_offset[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_load  = {16'd0, w_shifted[15:0]};
            end
            F3_W: begin
                o_legal = w_dir_ok && (i_offset == 2'b00);
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_load  = w_shifted;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_unit.sv
// Load/store unit: turns core MemRead/MemWrite requests into word-aligned bus
// transactions with byte enables, a response timeout and extended load data.
module lsu_mem_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_unit_if.slave io_lsu
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       r_state;
    lsu_state_e       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [2:0]       r_funct3;
    logic             r_is_load;
    logic [3:0]       r_bus_be;
    logic [31:0]      r_bus_wdata;
    logic [31:0]      r_rdata;
    logic             r_misaligned;
    logic             r_bus_error;

    logic             w_idle;
    logic             w_sel_read;
    logic [2:0]       w_sel_funct3;
    logic [1:0]       w_sel_offset;
    logic             w_legal;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load;
    logic             w_accept;
    logic             w_timeout;
    logic             w_capture;
    logic             w_set_mis;
    logic             w_set_err;

    assign w_idle = (r_state == IDLE);

    // In IDLE the aligner judges the incoming request; afterwards it serves the latched one.
    assign w_sel_read   = w_idle ? io_lsu.mem_read : r_is_load;
    assign w_sel_funct3 = w_idle ? io_lsu.funct3   : r_funct3;
    assign w_sel_offset = w_idle ? io_lsu.addr[1:0] : r_addr[1:0];

    lsu_align u_align (
        .i_mem_read  (w_sel_read),
        .i_mem_write (w_idle ? io_lsu.mem_write : !r_is_load),
        .i_funct3    (w_sel_funct3),
        .i_offset    (w_sel_offset),
        .i_wdata     (io_lsu.wdata),
        .i_rdata     (io_lsu.bus_rdata),
        .o_legal     (w_legal),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load      (w_load)
    );

    assign w_accept  = w_idle && io_lsu.req_valid && w_legal;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    assign io_lsu.busy       = !w_idle;
    assign io_lsu.done       = (r_state == DONE);
    assign io_lsu.rdata      = r_rdata;
    assign io_lsu.misaligned = r_misaligned;
    assign io_lsu.bus_error  = r_bus_error;
    assign io_lsu.bus_req    = (r_state == REQ);
    assign io_lsu.bus_we     = (r_state == REQ) && !r_is_load;
    assign io_lsu.bus_be     = r_bus_be;
    assign io_lsu.bus_addr   = {r_addr[31:2], 2'b00};
    assign io_lsu.bus_wdata  = r_bus_wdata;

    // A response in the final allowed cycle still wins over the timeout.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_set_mis    = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_lsu.req_valid) begin
                    if (w_legal) begin
                        w_next_state = REQ;
                    end else begin
                        w_next_state = DONE;
                        w_set_mis    = 1'b1;
                    end
                end
            end
            REQ: begin
                if (io_lsu.bus_gnt && !r_is_load) begin
                    w_next_state = DONE;
                end else if (io_lsu.bus_gnt && io_lsu.bus_rvalid) begin
                    w_next_state = DONE;
                    w_capture    = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = DONE;
                    w_set_err    = 1'b1;
                end else if (io_lsu.bus_gnt) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (io_lsu.bus_rvalid) begin
                    w_next_state = DONE;
                    w_capture    = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = DONE;
                    w_set_err    = 1'b1;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_funct3     <= '0;
            r_is_load    <= 1'b0;
            r_bus_be     <= '0;
            r_bus_wdata  <= '0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_misaligned <= w_set_mis;
            r_bus_error  <= w_set_err;
            r_cnt        <= w_idle ? '0 : r_cnt + CNT_W'(1);
            if (w_accept) begin
                r_addr      <= io_lsu.addr;
                r_funct3    <= io_lsu.funct3;
                r_is_load   <= io_lsu.mem_read;
                r_bus_be    <= w_be;
                r_bus_wdata <= w_wdata;
            end
            if (w_capture) begin
                r_rdata <= w_load;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Randomized scoreboard bench for lsu_mem_unit against a behavioural model of
// legality, lane placement, extension, latency and timeout.
module tb_lsu_mem_unit;
    import lsu_pkg::*;

    localparam int TIMEOUT = 6;

    typedef struct {
        logic        mis;
        logic        err;
        logic [31:0] rdata;
        int          issue;
        int          lat;
    } expect_t;

    logic clk = 1'b0;
    logic rst;

    lsu_mem_unit_if io();

    lsu_mem_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_lsu (io)
    );

    always #5 clk = ~clk;

    expect_t     sbQ[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cycleNum   = 0;
    logic [31:0] modelRdata = '0;

    always @(posedge clk) cycleNum <= cycleNum + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycleNum);
        end
    endtask

    function automatic int sizeOf(input logic [2:0] f3);
        if (f3 == F3_B || f3 == F3_BU) return 1;
        if (f3 == F3_H || f3 == F3_HU) return 2;
        return 4;
    endfunction

    function automatic bit modelLegal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (rd == wr) return 0;
        if (f3 == F3_B)  return 1;
        if (f3 == F3_BU) return rd;
        if (f3 == F3_H)  return (off % 2) == 0;
        if (f3 == F3_HU) return rd && ((off % 2) == 0);
        if (f3 == F3_W)  return off == 0;
        return 0;
    endfunction

    function automatic logic [3:0] modelBe(input int n, input int off);
        int v;
        v = ((1 << n) - 1) << off;
        return v[3:0];
    endfunction

    function automatic logic [31:0] modelWdata(input int n, input logic [31:0] wd);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input int off, input logic [31:0] word);
        longint one;
        longint v;
        int     n;
        one = 1;
        n   = sizeOf(f3);
        v   = (longint'(word) >> (8 * off)) % (one << (8 * n));
        if ((f3 == F3_B || f3 == F3_H) && v >= (one << (8 * n - 1)))
            v = v - (one << (8 * n));
        return v[31:0];
    endfunction

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        expect_t e;
        if (rst === 1'b0 && io.done === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("done_unexpected", io.done, 1'b0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("misaligned", io.misaligned, e.mis);
                checkOutput("bus_error", io.bus_error, e.err);
                checkOutput("rdata", io.rdata, e.rdata);
                checkOutput("latency", cycleNum - e.issue, e.lat);
                checkOutput("bus_req_at_done", io.bus_req, 1'b0);
            end
        end
    end

    task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input int g, input int r, input logic [31:0] word);
        expect_t e;
        bit      legal;
        bit      finished;
        int      n;
        int      off;
        int      c;
        int      k;
        legal   = modelLegal(rd, wr, f3, a);
        n       = sizeOf(f3);
        off     = int'(a % 4);
        e.issue = cycleNum;
        e.mis   = 1'b0;
        e.err   = 1'b0;
        if (!legal) begin
            e.mis = 1'b1;
            e.lat = 1;
        end else begin
            c = rd ? g + r : g;
            if (TIMEOUT != 0 && c > TIMEOUT - 1) begin
                e.err = 1'b1;
                e.lat = TIMEOUT + 1;
            end else begin
                e.lat = c + 2;
                if (rd) modelRdata = modelLoad(f3, off, word);
            end
        end
        e.rdata = modelRdata;
        sbQ.push_back(e);

        io.req_valid = 1'b1;
        io.mem_read  = rd;
        io.mem_write = wr;
        io.funct3    = f3;
        io.addr      = a;
        io.wdata     = wd;
        k        = 0;
        finished = 0;
        for (int i = 0; i < 400 && !finished; i++) begin
            @(negedge clk);
            // Core inputs are garbage while busy; the unit must ignore them.
            io.req_valid  = 1'($urandom_range(0, 1));
            io.mem_read   = 1'($urandom_range(0, 1));
            io.mem_write  = 1'($urandom_range(0, 1));
            io.funct3     = 3'($urandom_range(0, 7));
            io.addr       = $urandom;
            io.wdata      = $urandom;
            io.bus_gnt    = 1'b0;
            io.bus_rvalid = 1'b0;
            io.bus_rdata  = $urandom;
            if (io.done === 1'b1) begin
                finished = 1;
            end else begin
                if (k <= g) begin
                    checkOutput("bus_req", io.bus_req, 1'b1);
                    checkOutput("bus_we", io.bus_we, wr);
                    checkOutput("bus_be", io.bus_be, modelBe(n, off));
                    checkOutput("bus_addr", io.bus_addr, a - (a % 4));
                    checkOutput("bus_wdata", io.bus_wdata, wr ? modelWdata(n, wd) : io.bus_wdata);
                end else begin
                    checkOutput("bus_req_wait", io.bus_req, 1'b0);
                end
                if (k == g) io.bus_gnt = 1'b1;
                if (rd && k == g + r) begin
                    io.bus_rvalid = 1'b1;
                    io.bus_rdata  = word;
                end else if (k < g) begin
                    io.bus_rvalid = 1'($urandom_range(0, 1));
                end
                k++;
            end
        end
        if (!finished) checkOutput("done_never_seen", io.done, 1'b1);
        io.req_valid  = 1'b0;
        io.bus_gnt    = 1'b0;
        io.bus_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_done", io.busy, 1'b0);
    endtask

    logic [2:0] f3Table [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

    initial begin
        int          dirSel;
        int          idx;
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        rst           = 1'b1;
        io.req_valid  = 1'b0;
        io.mem_read   = 1'b0;
        io.mem_write  = 1'b0;
        io.funct3     = 3'b000;
        io.addr       = '0;
        io.wdata      = '0;
        io.bus_gnt    = 1'b0;
        io.bus_rvalid = 1'b0;
        io.bus_rdata  = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", io.busy, 1'b0);
        checkOutput("rst_done", io.done, 1'b0);
        checkOutput("rst_misaligned", io.misaligned, 1'b0);
        checkOutput("rst_bus_error", io.bus_error, 1'b0);
        checkOutput("rst_bus_req", io.bus_req, 1'b0);
        checkOutput("rst_bus_we", io.bus_we, 1'b0);
        checkOutput("rst_bus_be", io.bus_be, 4'b0000);
        checkOutput("rst_rdata", io.rdata, 32'h0);
        checkOutput("rst_bus_addr", io.bus_addr, 32'h0);
        checkOutput("rst_bus_wdata", io.bus_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(0, 1, F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0);
        applyStimulus(0, 1, F3_B,  32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0);
        applyStimulus(0, 1, F3_H,  32'h0000_0102, 32'h1234_5678, 2, 0, 32'h0);
        applyStimulus(1, 0, F3_B,  32'h0000_0101, 32'h0,         0, 3, 32'h0000_F000);
        applyStimulus(1, 0, F3_BU, 32'h0000_0101, 32'h0,         0, 3, 32'h0000_F000);
        applyStimulus(1, 0, F3_HU, 32'h0000_0102, 32'h0,         0, 3, 32'h8000_0000);
        applyStimulus(1, 0, F3_H,  32'h0000_01F0, 32'h0,         2, 0, 32'h8001_7FFF);
        applyStimulus(1, 0, F3_W,  32'h0000_0102, 32'h0,         0, 0, 32'h1111_1111);
        applyStimulus(1, 1, F3_W,  32'h0000_0100, 32'h0,         0, 0, 32'h2222_2222);
        applyStimulus(0, 1, F3_BU, 32'h0000_0100, 32'h0,         0, 0, 32'h0);
        applyStimulus(1, 0, F3_W,  32'h0000_0300, 32'h0,         0, 1000, 32'h3333_3333);
        applyStimulus(0, 1, F3_W,  32'h0000_0400, 32'hCAFE_F00D, 20, 0, 32'h0);

        for (int t = 0; t < 250; t++) begin
            dirSel = $urandom_range(0, 19);
            if (dirSel == 0)      begin rd = 1; wr = 1; end
            else if (dirSel == 1) begin rd = 0; wr = 0; end
            else if (dirSel < 11) begin rd = 1; wr = 0; end
            else                  begin rd = 0; wr = 1; end
            idx = $urandom_range(0, 5);
            f3  = (idx == 5) ? 3'($urandom_range(0, 7)) : f3Table[idx];
            applyStimulus(rd, wr, f3, $urandom, $urandom,
                          $urandom_range(0, 7), $urandom_range(0, 4), $urandom);
        end

        // Reset while waiting for read data: the late response must be dropped.
        io.req_valid = 1'b1;
        io.mem_read  = 1'b1;
        io.mem_write = 1'b0;
        io.funct3    = F3_W;
        io.addr      = 32'h0000_0200;
        @(negedge clk);
        io.req_valid = 1'b0;
        io.bus_gnt   = 1'b1;
        @(negedge clk);
        io.bus_gnt   = 1'b0;
        @(negedge clk);
        checkOutput("busy_in_wait", io.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        modelRdata    = '0;
        checkOutput("reset_busy", io.busy, 1'b0);
        checkOutput("reset_bus_req", io.bus_req, 1'b0);
        checkOutput("reset_rdata", io.rdata, 32'h0);
        io.bus_rvalid = 1'b1;
        io.bus_rdata  = 32'h5A5A_5A5A;
        @(negedge clk);
        io.bus_rvalid = 1'b0;
        checkOutput("late_rvalid_done", io.done, 1'b0);
        checkOutput("late_rvalid_busy", io.busy, 1'b0);
        checkOutput("late_rvalid_rdata", io.rdata, 32'h0);

        applyStimulus(1, 0, F3_B, 32'h0000_0203, 32'h0, 1, 1, 32'h8000_0000);

        repeat (3) @(negedge clk);
        if (sbQ.size() != 0) checkOutput("scoreboard_leftover", sbQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
